// File: rtl/weight_extraction_sequencer.sv
// weight_extraction_sequencer: clears, feeds and drains one weight-extraction pass across N cells; optional abort via WEC_SEQ_ABORT_EN
module weight_extraction_sequencer #(
    parameter int N     = 3,
    parameter int SKEW  = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [CNT_W-1:0] num_beats,
    input  logic             in_valid,
`ifdef WEC_SEQ_ABORT_EN
    input  logic             abort,
    output logic             aborted,
`endif
    output logic             in_ready,
    output logic             cell_rst,
    output logic [N-1:0]     cell_en,
    output logic [CNT_W-1:0] beat_cnt,
    output logic             busy,
    output logic             done,
    output logic             wk_valid
);
    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_DONE} state_t;
    localparam int DL = (N - 1) * SKEW;
    localparam int SW = DL > 0 ? DL : 1;
    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_num, r_cnt;
    logic [15:0]      r_drain;
    logic [SW-1:0]    r_sh;
    logic             r_wk, w_accept, w_go, w_abort;
    assign in_ready = r_state == S_FEED;
    assign cell_rst = r_state == S_CLEAR;
    assign busy     = cell_rst | in_ready | (r_state == S_DRAIN);
    assign done     = r_state == S_DONE;
    assign w_accept = in_valid & in_ready;
    assign w_go     = go & (r_state == S_IDLE);
    assign beat_cnt = r_cnt;
    assign wk_valid = r_wk;
    assign cell_en[0] = w_accept;
    for (genvar j = 1; j < N; j++) begin : g_col
        assign cell_en[j] = r_sh[j*SKEW-1];
    end
`ifdef WEC_SEQ_ABORT_EN
    logic r_aborted;
    assign w_abort = abort & busy;
    assign aborted = r_aborted;
    // one-cycle pulse marking an abandoned pass
    always_ff @(posedge clk or posedge rst)
        if (rst) r_aborted <= 1'b0;
        else r_aborted <= w_abort;
`else
    assign w_abort = 1'b0;
`endif
    // next-state: a zero-length drain (N==1) goes straight to DONE
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = go ? S_CLEAR : S_IDLE;
            S_CLEAR: w_next = (r_num != '0) ? S_FEED : (DL == 0 ? S_DONE : S_DRAIN);
            S_FEED:  w_next = (w_accept && (r_cnt + 1'b1 == r_num)) ? (DL == 0 ? S_DONE : S_DRAIN) : S_FEED;
            S_DRAIN: w_next = (r_drain == 16'(DL - 1)) ? S_DONE : S_DRAIN;
            default: w_next = S_IDLE;
        endcase
        if (w_abort) w_next = S_IDLE;
    end
    // state, captured beat target, progress and weight-valid flag
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_state <= S_IDLE;
            r_num   <= '0;
            r_cnt   <= '0;
            r_drain <= '0;
            r_wk    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_num   <= w_go ? num_beats : r_num;
            r_cnt   <= w_go ? '0 : r_cnt + CNT_W'(w_accept);
            r_drain <= (r_state == S_DRAIN) ? r_drain + 1'b1 : '0;
            r_wk    <= w_go ? 1'b0 : (r_wk | (w_next == S_DONE));
        end
    // skew line shifts every cycle so bubbles travel down the columns; abort flushes it
    always_ff @(posedge clk or posedge rst)
        if (rst) r_sh <= '0;
        else r_sh <= w_abort ? '0 : SW'({r_sh, w_accept});
endmodule

// File: tb/tb_weight_extraction_sequencer.sv
// tb_weight_extraction_sequencer: randomized passes scored against an event-time reference model
module tb_weight_extraction_sequencer;
    localparam int N = 3, SKEW = 1, CNT_W = 8, DL = (N - 1) * SKEW;
    logic clk = 0, rst = 1, go = 0, in_valid = 0;
    logic [CNT_W-1:0] num_beats = 0;
    logic in_ready, cell_rst, busy, done, wk_valid;
    logic [N-1:0] cell_en;
    logic [CNT_W-1:0] beat_cnt;
`ifdef WEC_SEQ_ABORT_EN
    logic abort = 0, aborted;
`endif
    int cyc = 0, vectors = 0, miscompares = 0;
    bit mon_on = 0;
    int q_rst[$], q_done[$], q_beats[$];
    int q_en[N][$];
    bit exp_busy[int];

    weight_extraction_sequencer #(.N(N), .SKEW(SKEW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .go(go), .num_beats(num_beats), .in_valid(in_valid),
`ifdef WEC_SEQ_ABORT_EN
        .abort(abort), .aborted(aborted),
`endif
        .in_ready(in_ready), .cell_rst(cell_rst), .cell_en(cell_en), .beat_cnt(beat_cnt),
        .busy(busy), .done(done), .wk_valid(wk_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, act, exp);
        end
    endtask

    // monitor: pops expected event times whenever the DUT shows an event
    always @(negedge clk) if (mon_on) begin
        check("busy", int'(busy), int'(exp_busy.exists(cyc)));
        check("rst_en_overlap", int'(cell_rst & (|cell_en)), 0);
        if (cell_rst) begin
            check("cell_rst_cycle", cyc, q_rst.size() ? q_rst.pop_front() : -1);
            check("wk_valid_cleared", int'(wk_valid), 0);
        end
        for (int j = 0; j < N; j++)
            if (cell_en[j]) check($sformatf("cell_en%0d_cycle", j), cyc, q_en[j].size() ? q_en[j].pop_front() : -1);
        if (done) begin
            check("done_cycle", cyc, q_done.size() ? q_done.pop_front() : -1);
            check("beat_cnt_at_done", int'(beat_cnt), q_beats.size() ? q_beats.pop_front() : -1);
            check("wk_valid_at_done", int'(wk_valid), 1);
        end
    end

    task automatic step(input bit rand_go);
        @(posedge clk); #1;
        go = rand_go ? ($urandom_range(0, 3) == 0) : 1'b0;
        num_beats = CNT_W'($urandom);
        in_valid = $urandom_range(0, 1);
    endtask

    task automatic push_beat(input int t, input int limit);
        for (int j = 0; j < N; j++)
            if (t + j * SKEW <= limit) q_en[j].push_back(t + j * SKEW);
    endtask

    // model: FEED starts two cycles after go; done lands DL+1 cycles after the last accepted beat
    task automatic run_pass(input int n, input int pv);
        int g, cnt, last, d;
        repeat ($urandom_range(0, 2)) step(0);
        @(posedge clk); #1;
        go = 1; num_beats = CNT_W'(n); in_valid = $urandom_range(0, 1); g = cyc;
        q_rst.push_back(g + 1);
        step(1); exp_busy[cyc] = 1;
        cnt = 0; last = g + 1;
        while (cnt < n) begin
            step(1);
            in_valid = $urandom_range(0, 99) < pv;
            exp_busy[cyc] = 1;
            if (in_valid) begin
                push_beat(cyc, 1 << 30);
                cnt++;
                last = cyc;
            end
        end
        d = last + 1 + DL;
        q_done.push_back(d);
        q_beats.push_back(n);
        while (cyc < d) begin
            step(1);
            if (cyc < d) exp_busy[cyc] = 1;
        end
    endtask

    task automatic reset_mid(input int n, input int k);
        int g;
        @(posedge clk); #1;
        go = 1; num_beats = CNT_W'(n); in_valid = 1; g = cyc;
        q_rst.push_back(g + 1);
        for (int c = g + 1; c < g + k; c++) exp_busy[c] = 1;
        for (int b = 0; b < n; b++) if (g + 2 + b < g + k) push_beat(g + 2 + b, g + k - 1);
        @(posedge clk); #1; go = 0;
        while (cyc < g + k) begin @(posedge clk); #1; end
        rst = 1;
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_cell_en", int'(cell_en), 0);
        check("rst_done", int'(done), 0);
        check("rst_wk_valid", int'(wk_valid), 0);
        check("rst_beat_cnt", int'(beat_cnt), 0);
        check("rst_in_ready", int'(in_ready), 0);
        @(posedge clk); #1; rst = 0;
        repeat (DL + 3) step(0);
        check("post_rst_wk_valid", int'(wk_valid), 0);
    endtask

`ifdef WEC_SEQ_ABORT_EN
    task automatic abort_mid();
        int g, a;
        @(posedge clk); #1;
        go = 1; num_beats = 4; in_valid = 1; g = cyc; a = g + 4;
        q_rst.push_back(g + 1);
        for (int c = g + 1; c <= a; c++) exp_busy[c] = 1;
        for (int t = g + 2; t <= a; t++) push_beat(t, a);
        @(posedge clk); #1; go = 0;
        while (cyc < a) begin @(posedge clk); #1; end
        abort = 1;
        @(posedge clk); #1; abort = 0; in_valid = 0;
        check("aborted_pulse", int'(aborted), 1);
        check("abort_beat_cnt", int'(beat_cnt), 3);
        check("abort_cell_en", int'(cell_en), 0);
        check("abort_wk_valid", int'(wk_valid), 0);
        @(posedge clk); #1;
        check("aborted_one_cycle", int'(aborted), 0);
        repeat (DL + 2) step(0);
    endtask
`endif

    initial begin
        @(posedge clk); #1;
        check("reset_busy", int'(busy), 0);
        check("reset_cell_en", int'(cell_en), 0);
        check("reset_done", int'(done), 0);
        check("reset_wk_valid", int'(wk_valid), 0);
        check("reset_beat_cnt", int'(beat_cnt), 0);
        check("reset_cell_rst", int'(cell_rst), 0);
        rst = 0;
        mon_on = 1;
        run_pass(4, 100);
        run_pass(0, 100);
        run_pass(1, 100);
        run_pass(4, 60);
        reset_mid(4, 4);
        for (int i = 0; i < 25; i++) run_pass($urandom_range(0, 7), $urandom_range(30, 100));
`ifdef WEC_SEQ_ABORT_EN
        abort_mid();
`endif
        run_pass(3, 100);
        repeat (DL + 3) step(0);
        check("q_rst_empty", q_rst.size(), 0);
        check("q_done_empty", q_done.size(), 0);
        for (int j = 0; j < N; j++) check($sformatf("q_en%0d_empty", j), q_en[j].size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
